// File: rtl/handshake_pkg.sv
// Shared constants and types for the handshake constant/sequence source.
package handshake_pkg;

    localparam int BUF_DEPTH = 2;
    localparam int IDX_WIDTH = 16;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Occupancy must represent 0..BUF_DEPTH inclusive.
    typedef logic [clog2(BUF_DEPTH + 1)-1:0] occ_t;

endpackage

// File: rtl/handshake_fifo2.sv
// Two-slot elastic buffer; slot0 is always the head, so dout is a plain register.
module handshake_fifo2
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output occ_t                  count
);

    logic [DATA_WIDTH-1:0] slot0;
    logic [DATA_WIDTH-1:0] slot1;
    occ_t                  count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot0   <= '0;
            slot1   <= '0;
            count_q <= '0;
        end else begin
            case (count_q)
                occ_t'(0): begin
                    if (push) begin
                        slot0   <= din;
                        count_q <= occ_t'(1);
                    end
                end
                occ_t'(1): begin
                    if (push && pop) begin
                        slot0 <= din;
                    end else if (push) begin
                        slot1   <= din;
                        count_q <= occ_t'(2);
                    end else if (pop) begin
                        count_q <= occ_t'(0);
                    end
                end
                occ_t'(2): begin
                    // Full: the upstream ready is low, so only a pop can happen.
                    if (pop) begin
                        slot0   <= slot1;
                        count_q <= occ_t'(1);
                    end
                end
                default: count_q <= '0;
            endcase
        end
    end

    assign dout       = slot0;
    assign dout_valid = (count_q != occ_t'(0));
    assign count      = count_q;

endmodule

// File: rtl/handshake_constant_seq.sv
// Emits one data token per accepted control token: a constant or a wrapping
// arithmetic sequence, buffered so ctrl_ready depends only on registered state.
module handshake_constant_seq
    import handshake_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] VALUE      = '0,
    parameter int                    STRIDE     = 1,
    parameter int unsigned           COUNT      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam logic [DATA_WIDTH-1:0] STRIDE_W = DATA_WIDTH'(STRIDE);
    localparam logic [IDX_WIDTH-1:0]  LAST     = IDX_WIDTH'((COUNT > 1) ? COUNT - 1 : 0);

    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] acc_next;
    logic [IDX_WIDTH-1:0]  idx;
    logic [IDX_WIDTH-1:0]  idx_next;
    occ_t                  count;
    logic                  accept;
    logic                  pop;

    assign ctrl_ready = (count < occ_t'(BUF_DEPTH));
    assign accept     = ctrl_valid && ctrl_ready;
    assign pop        = outs_valid && outs_ready;

    always_comb begin
        acc_next = acc;
        idx_next = idx;
        if (accept) begin
            if (COUNT == 1) begin
                acc_next = VALUE;
            end else if (COUNT == 0) begin
                acc_next = acc + STRIDE_W;
            end else if (idx == LAST) begin
                acc_next = VALUE;
                idx_next = '0;
            end else begin
                acc_next = acc + STRIDE_W;
                idx_next = idx + 1'b1;
            end
        end
        // The token pushed this cycle already carries the pre-restart acc.
        if (restart) begin
            acc_next = VALUE;
            idx_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= VALUE;
            idx <= '0;
        end else begin
            acc <= acc_next;
            idx <= idx_next;
        end
    end

    handshake_fifo2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .pop       (pop),
        .din       (acc),
        .dout      (outs),
        .dout_valid(outs_valid),
        .count     (count)
    );

endmodule

// File: doc/handshake_constant_seq.md
Name: handshake_constant_seq

Overview:
Parametrised successor to the fixed-value handshake constant. Each accepted control token emits one data token. The emitted value is either a fixed constant or an arithmetic sequence VALUE, VALUE+STRIDE, … that wraps after COUNT tokens. A 2-slot output buffer registers the ctrl_ready path, so there is no combinational ready chain through the block. It sits between the control network and a dataflow consumer, for example as a loop-bound or address-stride source.

Parameters:
DATA_WIDTH, 32, width of outs and all value arithmetic.
VALUE, 0, first value of the sequence; the value emitted at every token when COUNT=1.
STRIDE, 1, increment added per token, modulo 2^DATA_WIDTH; two's complement, so negative strides are allowed.
COUNT, 1, sequence period, range 0..65535. 1 = pure constant. 0 = never wrap (free-running modulo 2^DATA_WIDTH).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
restart  in  1  synchronous pulse; rewinds the sequence to VALUE.
ctrl_valid  in  1  control token present.
ctrl_ready  out  1  block can accept a control token.
outs  out  DATA_WIDTH  head-of-buffer value.
outs_valid  out  1  head-of-buffer valid.
outs_ready  in  1  consumer accepts.

Behaviour:
- Reset: one clock; rst is asynchronous and active-low.
  - rst=0 asynchronously sets the following, and holds them while rst=0:
    - acc=VALUE, idx=0, buffer count=0, both slot registers=0;
    - therefore outs_valid=0, outs=0, ctrl_ready=1.
- Handshakes:
  - accept = ctrl_valid & ctrl_ready.
  - pop = outs_valid & outs_ready.
  - ctrl_ready = (count<2); it is a function of registered state only and does not depend on outs_ready.
- Push: on accept, the current acc is written to the buffer tail.
- Sequence update on accept:
  - COUNT=1: acc is held at VALUE.
  - COUNT=0: acc <= acc+STRIDE, truncated to DATA_WIDTH.
  - COUNT>1:
    - if idx==COUNT-1: idx<=0 and acc<=VALUE;
    - otherwise: idx<=idx+1 and acc<=acc+STRIDE.
  - idx is 16 bits wide.
- Restart:
  - restart=1 sets acc<=VALUE and idx<=0 at the next edge.
  - If restart and accept occur in the same cycle, the accepted token takes the pre-restart acc, and restart then overrides the sequence update. The next token carries VALUE.
  - restart never flushes the buffer.
- Latency: 1 cycle. A token accepted at edge N appears with outs_valid=1 after edge N. There is no combinational ctrl-to-outs path.
- Buffer: 2-slot FIFO; outs and outs_valid are driven from the head slot.
  - count=0: no pop is possible; a push gives count=1.
  - count=1: push and pop together keep count=1 and the head becomes the new token; push only gives count=2; pop only gives count=0.
  - count=2: ctrl_ready=0, so no push; a pop gives count=1.
  - Order is preserved in all cases.
- Output stability: outs and outs_valid hold while outs_valid=1 and outs_ready=0.
- Reset mid-operation: buffered tokens are discarded, and the sequence restarts at VALUE after reset is released.

Decomposition:
- Shared package handshake_pkg:
  - constant BUF_DEPTH=2;
  - constant IDX_WIDTH=16;
  - function clog2;
  - typedef for the 2-bit occupancy count.
- Sub-module handshake_fifo2: 2-slot elastic buffer with push/pop/count and asynchronous active-low reset, parametrised by DATA_WIDTH.
- The top level holds the acc/idx sequence logic and instantiates handshake_fifo2.

Test Plan:
1. Reset released, ctrl_valid=1, outs_ready=1, defaults (VALUE=0, COUNT=1) -> one cycle after the first accept, outs_valid=1 and outs=0 on every cycle, one token per cycle.
2. VALUE=3, STRIDE=2, COUNT=4, outs_ready=1, 10 tokens -> outs sequence 3,5,7,9,3,5,7,9,3,5.
3. COUNT=0, DATA_WIDTH=8, VALUE=250, STRIDE=3, 4 tokens -> outs 250,253,0,3 (modulo wrap).
4. outs_ready=0, ctrl_valid=1 -> two tokens accepted, then ctrl_ready=0. outs holds its first value. Raising outs_ready drains both tokens in order, and ctrl_ready=1 returns after the first pop.
5. COUNT=4, VALUE=3, STRIDE=2; after tokens 3,5, restart is asserted in the same cycle as the accept of token 7 -> outs 3,5,7,3,5; buffer contents are kept.
6. Buffer full, rst pulsed low for less than one cycle mid-stream -> outs_valid=0 and ctrl_ready=1 immediately (asynchronous). After release, the next token is VALUE.
